// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared types, defaults and the line-address match helper used by
//            the write-back buffer.
// Revision : 1.0
// ============================================================================
package cache_pkg;

    localparam int c_addr_w  = 32;
    localparam int c_data_w  = 32;
    localparam int c_match_w = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAIN_REQ = 2'd1,
        FILL_REQ  = 2'd2,
        FILL_WAIT = 2'd3
    } wbb_state_t;

    // Callers zero-extend their addresses; the byte offset [1:0] never participates.
    function automatic logic line_match(input logic [c_match_w-1:0] a,
                                        input logic [c_match_w-1:0] b);
        return a[c_match_w-1:2] == b[c_match_w-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbb_store.sv
`default_nettype none
// ============================================================================
// Module   : wbb_store
// Brief    : Circular eviction store with valid bits, coalesce lookup for new
//            evictions and youngest-match lookup for fill forwarding.
// Revision : 1.0
// ============================================================================
module wbb_store
    import cache_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [ADDR_W-1:0]          i_push_addr,
    input  logic [DATA_W-1:0]          i_push_data,
    input  logic                       i_pop,
    input  logic                       i_head_busy,
    input  logic [ADDR_W-1:0]          i_fill_addr,
    output logic                       o_coal_hit,
    output logic                       o_fwd_hit,
    output logic [DATA_W-1:0]          o_fwd_data,
    output logic [ADDR_W-1:0]          o_head_addr,
    output logic [DATA_W-1:0]          o_head_data,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [c_ptr_w-1:0] w_idx;
    logic [c_ptr_w-1:0] w_coal_idx;
    logic [c_ptr_w-1:0] w_fwd_idx;
    logic               w_coal_hit;
    logic               w_fwd_hit;
    logic               w_push_new;

    // Walk oldest to youngest so the last forward match is the youngest copy.
    always_comb begin
        w_idx      = '0;
        w_coal_idx = '0;
        w_fwd_idx  = '0;
        w_coal_hit = 1'b0;
        w_fwd_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + c_ptr_w'(i);
            if (r_valid[w_idx] && !(i_head_busy && (i == 0)) &&
                line_match(c_match_w'(i_push_addr), c_match_w'(r_addr[w_idx]))) begin
                w_coal_hit = 1'b1;
                w_coal_idx = w_idx;
            end
            if (r_valid[w_idx] &&
                line_match(c_match_w'(i_fill_addr), c_match_w'(r_addr[w_idx]))) begin
                w_fwd_hit = 1'b1;
                w_fwd_idx = w_idx;
            end
        end
    end

    assign w_push_new = i_push && !w_coal_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_new) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (w_push_new && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_new && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_push_new) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end else if (i_push) begin
            r_data[w_coal_idx] <= i_push_data;
        end
    end

    assign o_coal_hit  = w_coal_hit;
    assign o_fwd_hit   = w_fwd_hit;
    assign o_fwd_data  = r_data[w_fwd_idx];
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_full      = (r_count == c_cnt_w'(DEPTH));
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : writeback_buffer
// Brief    : Eviction FIFO between a write-back cache and memory; drains in
//            the background and forwards buffered lines to cache fills.
// Revision : 1.0
// ============================================================================
module writeback_buffer
    import cache_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       evict_valid,
    output logic                       evict_ready,
    input  logic [ADDR_W-1:0]          evict_addr,
    input  logic [DATA_W-1:0]          evict_data,
    input  logic                       fill_req_valid,
    output logic                       fill_req_ready,
    input  logic [ADDR_W-1:0]          fill_addr,
    output logic                       fill_resp_valid,
    output logic [DATA_W-1:0]          fill_resp_data,
    output logic                       fill_from_buf,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_write,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_wdata,
    input  logic                       mem_resp_valid,
    input  logic [DATA_W-1:0]          mem_resp_rdata,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);

    wbb_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fill_addr;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_from_buf;

    logic              w_coal_hit, w_store_hit, w_full, w_push, w_pop, w_fill_acc;
    logic              w_same_cycle_hit, w_fwd;
    logic [DATA_W-1:0] w_store_data, w_fwd_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_resp_load, w_resp_from_buf, w_fill_latch;
    logic [DATA_W-1:0] w_resp_data;

    wbb_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_addr (evict_addr),
        .i_push_data (evict_data),
        .i_pop       (w_pop),
        .i_head_busy (r_state == DRAIN_REQ),
        .i_fill_addr (fill_addr),
        .o_coal_hit  (w_coal_hit),
        .o_fwd_hit   (w_store_hit),
        .o_fwd_data  (w_store_data),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_count     (buf_count)
    );

    assign evict_ready    = !w_full || w_coal_hit;
    assign w_push         = evict_valid && evict_ready;
    assign fill_req_ready = (r_state == IDLE);
    assign w_fill_acc     = fill_req_valid && fill_req_ready;

    // A same-cycle eviction is newer than anything already stored.
    assign w_same_cycle_hit = w_push && line_match(c_match_w'(evict_addr), c_match_w'(fill_addr));
    assign w_fwd            = w_same_cycle_hit || w_store_hit;
    assign w_fwd_data       = w_same_cycle_hit ? evict_data : w_store_data;

    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_resp_load     = 1'b0;
        w_resp_data     = '0;
        w_resp_from_buf = 1'b0;
        w_fill_latch    = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = '0;
        mem_req_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_fill_acc) begin
                    if (w_fwd) begin
                        w_resp_load     = 1'b1;
                        w_resp_data     = w_fwd_data;
                        w_resp_from_buf = 1'b1;
                    end else begin
                        w_fill_latch = 1'b1;
                        w_state_nxt  = FILL_REQ;
                    end
                end else if (buf_count != '0) begin
                    w_state_nxt = DRAIN_REQ;
                end
            end
            DRAIN_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = w_head_addr;
                mem_req_wdata = w_head_data;
                if (mem_req_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_fill_addr;
                if (mem_req_ready) begin
                    w_state_nxt = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    w_resp_load = 1'b1;
                    w_resp_data = mem_resp_rdata;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_fill_addr  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_from_buf   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_resp_load;
            if (w_fill_latch) begin
                r_fill_addr <= fill_addr;
            end
            if (w_resp_load) begin
                r_resp_data <= w_resp_data;
                r_from_buf  <= w_resp_from_buf;
            end
        end
    end

    assign fill_resp_valid = r_resp_valid;
    assign fill_resp_data  = r_resp_data;
    assign fill_from_buf   = r_from_buf;

endmodule
`default_nettype wire

// File: tb/tb_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_buffer
// Brief    : Scoreboard bench for writeback_buffer: memory writes, memory
//            reads and fill responses are predicted and compared on arrival.
// Revision : 1.0
// ============================================================================
module tb_writeback_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        evict_valid, evict_ready;
    logic [31:0] evict_addr, evict_data;
    logic        fill_req_valid, fill_req_ready;
    logic [31:0] fill_addr;
    logic        fill_resp_valid;
    logic [31:0] fill_resp_data;
    logic        fill_from_buf;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [2:0]  buf_count;

    writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .evict_valid     (evict_valid),
        .evict_ready     (evict_ready),
        .evict_addr      (evict_addr),
        .evict_data      (evict_data),
        .fill_req_valid  (fill_req_valid),
        .fill_req_ready  (fill_req_ready),
        .fill_addr       (fill_addr),
        .fill_resp_valid (fill_resp_valid),
        .fill_resp_data  (fill_resp_data),
        .fill_from_buf   (fill_from_buf),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata),
        .buf_count       (buf_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        logic        from_buf;
        int          at;
    } fr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    fr_t         exp_fill[$];
    wr_t         mw;
    fr_t         mf;
    logic [31:0] mr;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every handshake and response is matched against the prediction queues.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_req_valid && mem_req_ready && mem_req_write) begin
                check("wr_expected", 64'(exp_wr.size() > 0), 64'(1));
                if (exp_wr.size() > 0) begin
                    mw = exp_wr.pop_front();
                    check("wr_addr", 64'(mem_req_addr), 64'(mw.addr));
                    check("wr_data", 64'(mem_req_wdata), 64'(mw.data));
                end
            end
            if (mem_req_valid && mem_req_ready && !mem_req_write) begin
                check("rd_expected", 64'(exp_rd.size() > 0), 64'(1));
                if (exp_rd.size() > 0) begin
                    mr = exp_rd.pop_front();
                    check("rd_addr", 64'(mem_req_addr), 64'(mr));
                end
            end
            if (fill_resp_valid) begin
                check("fill_expected", 64'(exp_fill.size() > 0), 64'(1));
                if (exp_fill.size() > 0) begin
                    mf = exp_fill.pop_front();
                    check("fill_data", 64'(fill_resp_data), 64'(mf.data));
                    check("fill_from_buf", 64'(fill_from_buf), 64'(mf.from_buf));
                    if (mf.at >= 0) check("fill_latency", 64'(cyc), 64'(mf.at));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_evict(input logic [31:0] a, input logic [31:0] d, input int coal_idx);
        int k;
        k = 0;
        evict_valid = 1'b1;
        evict_addr  = a;
        evict_data  = d;
        @(negedge clk);
        while (!evict_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("evict_accept", 64'(evict_ready), 64'(1));
        if (evict_ready) begin
            if (coal_idx >= 0) exp_wr[coal_idx].data = d;
            else exp_wr.push_back('{a, d});
        end
        tick();
        evict_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a, input logic fwd, input logic [31:0] fdata);
        int k;
        k = 0;
        fill_req_valid = 1'b1;
        fill_addr      = a;
        @(negedge clk);
        while (!fill_req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("fill_accept", 64'(fill_req_ready), 64'(1));
        if (fill_req_ready) begin
            if (fwd) exp_fill.push_back('{fdata, 1'b1, cyc + 1});
            else exp_rd.push_back(a);
        end
        tick();
        fill_req_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int k;
        k = 0;
        while ((exp_wr.size() != 0 || buf_count != 3'd0) && k < 100) begin
            tick();
            k++;
        end
        tick();
        check("drain_count", 64'(buf_count), 64'(0));
        check("drain_queue", 64'(exp_wr.size()), 64'(0));
    endtask

    initial begin
        int k;
        reset          = 1'b1;
        evict_valid    = 1'b0;
        evict_addr     = '0;
        evict_data     = '0;
        fill_req_valid = 1'b0;
        fill_addr      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        #12;
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst_fill_resp_valid", 64'(fill_resp_valid), 64'(0));
        check("rst_fill_from_buf", 64'(fill_from_buf), 64'(0));
        check("rst_fill_resp_data", 64'(fill_resp_data), 64'(0));
        check("rst_buf_count", 64'(buf_count), 64'(0));
        check("rst_evict_ready", 64'(evict_ready), 64'(1));
        check("rst_fill_req_ready", 64'(fill_req_ready), 64'(1));
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1: three evictions, drained in push order
        do_evict(32'hAAAAA028, 32'h0000CD0A, -1);
        do_evict(32'hAAAAA02C, 32'h0000CD0B, -1);
        do_evict(32'hAAAAA030, 32'h0000CD0C, -1);
        @(negedge clk);
        check("t1_count3", 64'(buf_count), 64'(3));
        tick();
        mem_req_ready = 1'b1;
        wait_drained();

        // 2: forward from buffer, no memory read
        mem_req_ready = 1'b0;
        do_evict(32'hAAAAA028, 32'h12345678, -1);
        do_fill(32'hAAAAA028, 1'b1, 32'h12345678);
        tick();
        tick();
        mem_req_ready = 1'b1;
        wait_drained();

        // 3: memory fill, response one cycle after mem_resp_valid
        do_fill(32'hBBBBB028, 1'b0, 32'h0);
        tick();
        tick();
        exp_fill.push_back('{32'hDEADBEEF, 1'b0, cyc + 1});
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEADBEEF;
        tick();
        mem_resp_valid = 1'b0;
        repeat (3) tick();
        check("t3_rd_done", 64'(exp_rd.size()), 64'(0));
        // stray read data in IDLE must not produce a response
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h11111111;
        tick();
        mem_resp_valid = 1'b0;
        repeat (2) tick();
        check("t3_fill_done", 64'(exp_fill.size()), 64'(0));

        // 4: full buffer stalls new lines but coalesces a queued one
        mem_req_ready = 1'b0;
        do_evict(32'hAAAAA050, 32'h00000001, -1);
        do_evict(32'hAAAAA054, 32'h00000002, -1);
        do_evict(32'hAAAAA058, 32'h00000003, -1);
        do_evict(32'hAAAAA05C, 32'h00000004, -1);
        evict_valid = 1'b1;
        evict_addr  = 32'hAAAAA060;
        evict_data  = 32'h00000005;
        @(negedge clk);
        check("t4_full_stall", 64'(evict_ready), 64'(0));
        tick();
        @(negedge clk);
        check("t4_full_stall2", 64'(evict_ready), 64'(0));
        check("t4_count4", 64'(buf_count), 64'(4));
        tick();
        do_evict(32'hAAAAA058, 32'h0000FFFF, 2);
        @(negedge clk);
        check("t4_coal_count", 64'(buf_count), 64'(4));
        tick();
        mem_req_ready = 1'b1;
        wait_drained();

        // 5: same-cycle eviction and fill of one line
        evict_valid    = 1'b1;
        evict_addr     = 32'hAAAAA040;
        evict_data     = 32'h0BADF00D;
        fill_req_valid = 1'b1;
        fill_addr      = 32'hAAAAA040;
        @(negedge clk);
        check("t5_evict_ready", 64'(evict_ready), 64'(1));
        check("t5_fill_ready", 64'(fill_req_ready), 64'(1));
        if (evict_ready) exp_wr.push_back('{32'hAAAAA040, 32'h0BADF00D});
        if (fill_req_ready) exp_fill.push_back('{32'h0BADF00D, 1'b1, cyc + 1});
        tick();
        evict_valid    = 1'b0;
        fill_req_valid = 1'b0;
        wait_drained();
        check("t5_fill_done", 64'(exp_fill.size()), 64'(0));

        // 6: reset while a drain request is pending
        mem_req_ready = 1'b0;
        do_evict(32'hAAAAA070, 32'h00000077, -1);
        k = 0;
        @(negedge clk);
        while (!mem_req_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_drain_pending", 64'(mem_req_valid), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("t6_rst_buf_count", 64'(buf_count), 64'(0));
        check("t6_rst_evict_ready", 64'(evict_ready), 64'(1));
        exp_wr.delete();
        @(negedge clk);
        reset         = 1'b0;
        mem_req_ready = 1'b1;
        repeat (10) tick();
        check("t6_no_drain_count", 64'(buf_count), 64'(0));
        check("t6_mem_idle", 64'(mem_req_valid), 64'(0));

        check("end_rd_queue", 64'(exp_rd.size()), 64'(0));
        check("end_fill_queue", 64'(exp_fill.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
